// File: rtl/sd_pkg.sv
// Shared constants and state encodings for the SD image loading path.
// States are 5 bits wide so they can be muxed onto the controller status bus.
package sd_pkg;
  localparam int SD_BLOCK_BYTES = 512;

  typedef enum logic [4:0] {
    S_IDLE  = 5'd0,
    S_WAIT  = 5'd1,
    S_ISSUE = 5'd2,
    S_RECV  = 5'd3,
    S_END   = 5'd4,
    S_DONE  = 5'd5,
    S_ERR   = 5'd6
  } ld_state_t;
endpackage

// File: rtl/sd_watchdog.sv
// Saturating progress watchdog: clear restarts it, expired is the terminal-count flag.
module sd_watchdog #(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (enable && !expired)
      count <= count + 1'b1;
  end
endmodule

// File: rtl/sd_image_loader.sv
// Reads consecutive SD blocks, drops the file header and streams the image
// payload into a byte-wide frame-buffer write port.
module sd_image_loader
  import sd_pkg::*;
#(
  parameter int IMAGE_BYTES    = 76800,
  parameter int HEADER_BYTES   = 1078,
  parameter int ADDR_W         = 17,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       base_block,
  input  logic              sd_ready,
  output logic              sd_rd,
  output logic [31:0]       sd_address,
  input  logic [7:0]        sd_dout,
  input  logic              sd_byte_available,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       blocks_read
);
  localparam logic [15:0] NUM_BLOCKS =
    16'((HEADER_BYTES + IMAGE_BYTES + SD_BLOCK_BYTES - 1) / SD_BLOCK_BYTES);
  localparam logic [31:0] PAY_LO   = 32'(HEADER_BYTES);
  localparam logic [31:0] PAY_HI   = 32'(HEADER_BYTES + IMAGE_BYTES);
  localparam logic [9:0]  LAST_BYTE = 10'(SD_BLOCK_BYTES - 1);

  ld_state_t   state;
  logic [31:0] base;
  logic [15:0] blk_cnt;
  logic [9:0]  byte_in_blk;
  logic [31:0] stream_idx;
  logic        avail_q;
  logic        kick;
  logic        wd_expired;
  logic        byte_rise;
  logic        active;

  assign byte_rise = sd_byte_available & ~avail_q;
  assign active    = (state == S_WAIT) || (state == S_ISSUE) ||
                     (state == S_RECV) || (state == S_END);

  // kick is a registered pulse on every state change or captured byte
  sd_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clear   (kick || !active),
    .enable  (active),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      base        <= '0;
      blk_cnt     <= '0;
      byte_in_blk <= '0;
      stream_idx  <= '0;
      avail_q     <= 1'b0;
      kick        <= 1'b0;
      sd_rd       <= 1'b0;
      sd_address  <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      blocks_read <= '0;
    end else begin
      avail_q <= sd_byte_available;
      mem_we  <= 1'b0;
      kick    <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          base        <= base_block;
          blk_cnt     <= '0;
          blocks_read <= '0;
          stream_idx  <= '0;
          byte_in_blk <= '0;
          done        <= 1'b0;
          error       <= 1'b0;
          busy        <= 1'b1;
          kick        <= 1'b1;
          state       <= S_WAIT;
        end
        S_WAIT: if (sd_ready) begin
          sd_address <= base + {16'd0, blk_cnt};
          sd_rd      <= 1'b1;
          kick       <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: if (!sd_ready) begin
          sd_rd       <= 1'b0;
          byte_in_blk <= '0;
          kick        <= 1'b1;
          state       <= S_RECV;
        end
        S_RECV: if (byte_rise) begin
          kick        <= 1'b1;
          byte_in_blk <= byte_in_blk + 10'd1;
          stream_idx  <= stream_idx + 32'd1;
          if (stream_idx >= PAY_LO && stream_idx < PAY_HI) begin
            mem_we   <= 1'b1;
            mem_addr <= ADDR_W'(stream_idx - PAY_LO);
            mem_data <= sd_dout;
          end
          if (byte_in_blk == LAST_BYTE)
            state <= S_END;
        end
        // sd_ready returning means the controller has consumed the CRC
        S_END: if (sd_ready) begin
          blocks_read <= blocks_read + 16'd1;
          blk_cnt     <= blk_cnt + 16'd1;
          kick        <= 1'b1;
          state       <= (blk_cnt + 16'd1 == NUM_BLOCKS) ? S_DONE : S_WAIT;
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_ERR: begin
          busy  <= 1'b0;
          error <= 1'b1;
          sd_rd <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (wd_expired && active) begin
        state <= S_ERR;
        sd_rd <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sd_image_loader.sv
// Randomized bench: behavioural SD controller model feeding a scoreboard of
// expected frame-buffer writes, checked by an independent write monitor.
module tb_sd_image_loader;
  localparam int HDR = 4;
  localparam int IMG = 1000;
  localparam int AW  = 10;
  localparam int TO  = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   base_block;
  logic          sd_ready;
  logic          sd_rd;
  logic [31:0]   sd_address;
  logic [7:0]    sd_dout;
  logic          sd_byte_available;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [15:0]   blocks_read;

  sd_image_loader #(.IMAGE_BYTES(IMG), .HEADER_BYTES(HDR), .ADDR_W(AW),
                    .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .base_block(base_block),
    .sd_ready(sd_ready), .sd_rd(sd_rd), .sd_address(sd_address),
    .sd_dout(sd_dout), .sd_byte_available(sd_byte_available),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .error(error), .blocks_read(blocks_read)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [7:0] data; } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_addr_q[$];
  int checks = 0, failures = 0;
  int served = 0, writes = 0, rd_count = 0;
  int stall_en = 0, stall_blk = 0, stall_byte = 0, stall_hit = 0, force_w = 0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every strobe must match the oldest byte the model sent
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      exp_t e;
      writes++;
      chk("we_spacing", prev_we, 1'b0);
      if (exp_q.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_data", mem_data, e.data);
      end
    end
    prev_we = mem_we;
  end

  // One block as the controller would deliver it; aborts on reset
  task automatic serve_block();
    int lat, w, g, s, extra;
    logic [7:0] b;
    lat   = $urandom_range(1, 4);
    extra = $urandom_range(0, 2);
    for (int k = 0; k < lat; k++) begin tick(); if (reset) return; end
    for (int i = 0; i < 512 + extra; i++) begin
      while (stall_en != 0 && served == stall_blk && i == stall_byte && !reset) begin
        stall_hit = 1;
        tick();
      end
      if (reset) return;
      b = 8'($urandom_range(0, 255));
      s = served * 512 + i;
      if (i < 512 && s >= HDR && s < HDR + IMG) exp_q.push_back('{s - HDR, b});
      sd_dout = b;
      sd_byte_available = 1'b1;
      w = (force_w != 0) ? 3 : $urandom_range(1, 3);
      for (int k = 0; k < w; k++) begin tick(); if (reset) return; end
      sd_byte_available = 1'b0;
      g = $urandom_range(1, 2);
      for (int k = 0; k < g; k++) begin tick(); if (reset) return; end
    end
    served++;
    lat = $urandom_range(2, 5);
    for (int k = 0; k < lat; k++) begin tick(); if (reset) return; end
  endtask

  initial begin : sd_model
    sd_ready = 1'b1;
    sd_byte_available = 1'b0;
    sd_dout = 8'h00;
    forever begin
      tick();
      if (!reset && sd_ready && sd_rd) begin
        rd_count++;
        if (exp_addr_q.size() == 0) chk("unexpected_rd", 1'b1, 1'b0);
        else chk("sd_address", sd_address, exp_addr_q.pop_front());
        sd_ready = 1'b0;
        serve_block();
      end
      sd_ready = 1'b1;
      sd_byte_available = 1'b0;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_sd_rd"}, sd_rd, 0);
    chk({tag, "_sd_address"}, sd_address, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_data"}, mem_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_blocks_read"}, blocks_read, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    chk_zero("rst");
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    served = 0;
  endtask

  task automatic start_load(input logic [31:0] base);
    exp_addr_q.delete();
    exp_addr_q.push_back(base);
    exp_addr_q.push_back(base + 32'd1);
    served = 0; writes = 0; rd_count = 0;
    base_block = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    base_block = $urandom();
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
  endtask

  task automatic finish_load(input string tag);
    int cyc = 0;
    while (!(done || error) && cyc < 20000) begin tick(); cyc++; end
    chk({tag, "_completed"}, done | error, 1);
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_blocks_read"}, blocks_read, 2);
    chk({tag, "_writes"}, writes, IMG);
    chk({tag, "_rd_count"}, rd_count, 2);
    chk({tag, "_exp_left"}, exp_q.size(), 0);
    chk({tag, "_addr_left"}, exp_addr_q.size(), 0);
  endtask

  initial begin : stim
    int cyc;
    reset = 1'b1; start = 1'b0; base_block = '0;
    tick();
    chk_zero("por");
    tick();
    reset = 1'b0;
    tick();

    start_load(32'h0000_0100);
    finish_load("basic");

    for (int r = 0; r < 2; r++) begin
      start_load($urandom());
      finish_load("rand");
    end

    start_load(32'hFFFF_FFFF);
    finish_load("wrap");

    // Restart attempt mid-load plus wide byte pulses
    force_w = 1;
    start_load(32'h0000_5A00);
    repeat (300) tick();
    base_block = 32'h1234_5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_load("busy_start");
    force_w = 0;

    // Reset during the second block, then a clean restart
    start_load(32'h0000_0777);
    cyc = 0;
    while (served < 1 && cyc < 10000) begin tick(); cyc++; end
    chk("reach_blk2", served, 1);
    repeat (200) tick();
    pulse_reset();
    tick();
    start_load(32'h0000_0777);
    chk("restart_blocks_read", blocks_read, 0);
    finish_load("restart");

    // Stall inside block 1: watchdog must fire after TO idle cycles
    stall_en = 1; stall_blk = 1; stall_byte = 100; stall_hit = 0;
    start_load(32'h0000_2000);
    cyc = 0;
    while (stall_hit == 0 && cyc < 10000) begin tick(); cyc++; end
    chk("stall_reached", stall_hit, 1);
    cyc = 0;
    while (!error && cyc < 3 * TO) begin tick(); cyc++; end
    chk("wd_error", error, 1);
    chk("wd_window", (cyc >= TO - 10 && cyc <= TO + 10), 1);
    tick();
    chk("wd_busy", busy, 0);
    chk("wd_done", done, 0);
    chk("wd_sd_rd", sd_rd, 0);
    chk("wd_blocks_read", blocks_read, 1);
    pulse_reset();
    stall_en = 0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
